// File: rtl/temp_pkg.sv
// Shared constants and state type for the temperature sample averager.
package temp_pkg;

    localparam int TEMP_W     = 8;
    localparam int TEMP_LOG2N = 2;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/temp_sample_averager.sv
// Temperature sample averager: sums a window of 2^LOG2N raw samples and
// emits their mean over a valid/ready handshake.
// Optional build macro TEMP_AVG_ROUND_EN: round half up instead of truncating.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting samples, accumulating the current window
// HOLD  | result registered on avg_out, waiting for downstream avg_ready
module temp_sample_averager
    import temp_pkg::*;
#(
    parameter int W     = TEMP_W,
    parameter int LOG2N = TEMP_LOG2N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic [W-1:0]   sample_in,
    input  logic           sample_valid,
    output logic           sample_ready,
    output logic [W-1:0]   avg_out,
    output logic           avg_valid,
    input  logic           avg_ready,
    output logic [LOG2N:0] fill
);

    localparam int N  = 2 ** LOG2N;
    localparam int AW = W + LOG2N;
    localparam int SW = AW + 1;
    localparam int FW = LOG2N + 1;
`ifdef TEMP_AVG_ROUND_EN
    localparam int RND = N / 2;
`else
    localparam int RND = 0;
`endif
    localparam logic [LOG2N:0] LAST = FW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] raw_sum;
    logic [SW-1:0] rounded_sum;
    logic          accept;
    logic          last;

    // The full window sum never exceeds N*(2^W-1), so AW bits are enough;
    // the rounding term gets one extra bit of headroom before the shift.
    assign raw_sum     = acc + AW'(sample_in);
    assign rounded_sum = SW'(raw_sum) + SW'(RND);
    assign accept      = sample_valid && sample_ready && !flush;
    assign last        = (fill == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and input handshake; sample_ready is a pure function of state.
    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        case (state)
            ACCUM: begin
                sample_ready = 1'b1;
                if (accept && last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (avg_valid && avg_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulator, window count and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            fill      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (flush) begin
                        acc  <= '0;
                        fill <= '0;
                    end else if (accept) begin
                        if (last) begin
                            avg_out   <= W'(rounded_sum >> LOG2N);
                            avg_valid <= 1'b1;
                            acc       <= '0;
                            fill      <= '0;
                        end else begin
                            acc  <= raw_sum;
                            fill <= fill + FW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (avg_ready) begin
                        avg_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
